// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iir_pkg
// Purpose  : Shared encodings for the 2nd-order IIR MAC sequencer: state
//            codes, tap count, coefficient/operand selector codes and the
//            default multiplier latency.
// Revision : 1.0 - initial release
// ============================================================================
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    DRAIN  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  localparam int NUM_TAPS         = 5;
  localparam int MULT_LAT_DEFAULT = 1;

  // Selector codes shared by the coefficient mux and the operand mux.
  // Tap k pairs coefficient k with operand k.
  localparam logic [2:0] SEL_A1   = 3'd0;
  localparam logic [2:0] SEL_A2   = 3'd1;
  localparam logic [2:0] SEL_B0   = 3'd2;
  localparam logic [2:0] SEL_B1   = 3'd3;
  localparam logic [2:0] SEL_B2   = 3'd4;
  localparam logic [2:0] SEL_IDLE = 3'd5;

endpackage
`default_nettype wire

// File: rtl/valid_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module   : valid_delay_pipe
// Purpose  : N-stage 1-bit shift register with synchronous reset; N=0 is a
//            combinational pass-through. Aligns control bits with the
//            multiplier pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module valid_delay_pipe #(
  parameter int N = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  generate
    if (N == 0) begin : g_passthru
      // Clock and reset have no job without storage stages.
      logic w_unused;
      assign w_unused = clk ^ reset;
      assign dout     = din;
    end else begin : g_pipe
      logic [N-1:0] r_pipe;

      // Shift din through N stages; reset empties the pipe.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= din;
          for (int i = 1; i < N; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign dout = r_pipe[N-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/iir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : iir_mac_sequencer
// Purpose  : Steps the shared multiply-accumulate datapath of a 2nd-order IIR
//            through its five taps per sample, aligns accumulator control
//            with the multiplier latency, commands the delay-line shift and
//            flags the finished output sample.
// Revision : 1.0 - initial release
// ============================================================================
module iir_mac_sequencer
  import iir_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int NUM_TAPS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       ovr_clr,
  output logic [2:0] sel_const,
  output logic [2:0] sel_data,
  output logic       issue,
  output logic       acc_en,
  output logic       acc_clr,
  output logic       shift_en,
  output logic       y_valid,
  output logic       ready,
  output logic       overrun
);

  localparam logic [2:0] c_step_last  = 3'(NUM_TAPS - 1);
  // Step counter is reused to time the drain phase.
  localparam logic [2:0] c_drain_last = (MULT_LAT > 0) ? 3'(MULT_LAT - 1) : 3'd0;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_step;
  logic [2:0] w_step_nxt;
  logic       w_idle;
  logic       w_first;
  logic       r_overrun;

  // State and step counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_step  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Next-state, step counter and per-state datapath controls.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_idle      = 1'b0;
    issue       = 1'b0;
    sel_const   = SEL_IDLE;
    sel_data    = SEL_IDLE;
    shift_en    = 1'b0;
    y_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        w_idle = 1'b1;
        if (sample_tick) begin
          w_state_nxt = MAC;
          w_step_nxt  = 3'd0;
        end
      end
      MAC: begin
        issue     = 1'b1;
        sel_const = r_step;
        sel_data  = r_step;
        if (r_step == c_step_last) begin
          w_step_nxt  = 3'd0;
          w_state_nxt = (MULT_LAT > 0) ? DRAIN : UPDATE;
        end else begin
          w_step_nxt = r_step + 3'd1;
        end
      end
      DRAIN: begin
        if (r_step == c_drain_last) begin
          w_step_nxt  = 3'd0;
          w_state_nxt = UPDATE;
        end else begin
          w_step_nxt = r_step + 3'd1;
        end
      end
      UPDATE: begin
        shift_en    = 1'b1;
        y_valid     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_step_nxt  = 3'd0;
      end
    endcase
  end

  // Ready is masked while reset is held so every output shows its reset value.
  assign ready   = w_idle & ~reset;
  assign w_first = issue & (r_step == 3'd0);

  // Sticky overrun: an offending tick outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (sample_tick && !w_idle) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;

  valid_delay_pipe #(.N(MULT_LAT)) u_acc_en_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (issue),
    .dout  (acc_en)
  );

  valid_delay_pipe #(.N(MULT_LAT)) u_acc_clr_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (w_first),
    .dout  (acc_clr)
  );

endmodule
`default_nettype wire

// File: tb/tb_iir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_mac_sequencer
// Purpose  : Self-checking bench for iir_mac_sequencer with MULT_LAT=1 and
//            MULT_LAT=0 instances; y_valid timing checked via scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       reset = 1'b1;
  logic       tick1 = 1'b0, clr1 = 1'b0, tick0 = 1'b0, clr0 = 1'b0;
  logic [2:0] sel_const1, sel_data1, sel_const0, sel_data0;
  logic       issue1, acc_en1, acc_clr1, shift_en1, y_valid1, ready1, overrun1;
  logic       issue0, acc_en0, acc_clr0, shift_en0, y_valid0, ready0, overrun0;

  iir_mac_sequencer #(.MULT_LAT(1), .NUM_TAPS(5)) dut1 (
    .clk(clk), .reset(reset), .sample_tick(tick1), .ovr_clr(clr1),
    .sel_const(sel_const1), .sel_data(sel_data1), .issue(issue1),
    .acc_en(acc_en1), .acc_clr(acc_clr1), .shift_en(shift_en1),
    .y_valid(y_valid1), .ready(ready1), .overrun(overrun1)
  );

  iir_mac_sequencer #(.MULT_LAT(0), .NUM_TAPS(5)) dut0 (
    .clk(clk), .reset(reset), .sample_tick(tick0), .ovr_clr(clr0),
    .sel_const(sel_const0), .sel_data(sel_data0), .issue(issue0),
    .acc_en(acc_en0), .acc_clr(acc_clr0), .shift_en(shift_en0),
    .y_valid(y_valid0), .ready(ready0), .overrun(overrun0)
  );

  wire [12:0] obs1 = {issue1, acc_en1, acc_clr1, shift_en1, y_valid1, ready1,
                      overrun1, sel_const1, sel_data1};
  wire [12:0] obs0 = {issue0, acc_en0, acc_clr0, shift_en0, y_valid0, ready0,
                      overrun0, sel_const0, sel_data0};

  // Expected y_valid cycles, pushed when an accepted tick is driven.
  int sb1[$];
  int sb0[$];

  // Expected outputs at cycle r for a sample accepted at cycle t, latency l.
  function automatic logic [12:0] expv(int r, int t, int l, logic ov);
    logic       iss, ae, ac, upd, rdy;
    logic [2:0] sel;
    iss = (r >= t + 1) && (r <= t + 5);
    sel = iss ? 3'(r - t - 1) : 3'd5;
    ae  = (r >= t + 1 + l) && (r <= t + 5 + l);
    ac  = (r == t + 1 + l);
    upd = (r == t + 6 + l);
    rdy = !((r >= t + 1) && (r <= t + 6 + l));
    return {iss, ae, ac, upd, upd, rdy, ov, sel, sel};
  endfunction

  // Scoreboard monitors: each y_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && y_valid1) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected cyc=%0d got y_valid expected none", cyc);
      end else begin
        int e;
        e = sb1.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL sb1_timing got cyc=%0d expected cyc=%0d", cyc, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && y_valid0) begin
      checks++;
      if (sb0.size() == 0) begin
        errors++;
        $display("FAIL sb0_unexpected cyc=%0d got y_valid expected none", cyc);
      end else begin
        int e;
        e = sb0.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL sb0_timing got cyc=%0d expected cyc=%0d", cyc, e);
        end
      end
    end
  end

  // Leaves the bench 1 time unit after a rising edge, reset released.
  task automatic do_reset();
    reset = 1'b1;
    tick1 = 1'b0; clr1 = 1'b0; tick0 = 1'b0; clr0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = {7'b0, 3'd5, 3'd5};
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL reset_l1 obs=%b exp=%b", obs1, e); end
    checks++;
    if (obs0 !== e) begin errors++; $display("FAIL reset_l0 obs=%b exp=%b", obs0, e); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    e = expv(0, -100, 1, 1'b0);
    checks++;
    if (obs1 !== e) begin errors++; $display("FAIL post_reset_l1 obs=%b exp=%b", obs1, e); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_l1();
    logic [12:0] e;
    do_reset();
    for (int r = 0; r < 22; r++) begin
      tick1 = (r == 10);
      if (r == 10) sb1.push_back(cyc + 7);
      @(negedge clk);
      e = expv(r, 10, 1, 1'b0);
      checks++;
      if (obs1 !== e) begin
        errors++; $display("FAIL single_l1 r=%0d obs=%b exp=%b", r, obs1, e);
      end
      @(posedge clk);
      #1;
    end
    tick1 = 1'b0;
  endtask

  task automatic test_single_l0();
    logic [12:0] e;
    do_reset();
    for (int r = 0; r < 20; r++) begin
      tick0 = (r == 10);
      if (r == 10) sb0.push_back(cyc + 6);
      @(negedge clk);
      e = expv(r, 10, 0, 1'b0);
      checks++;
      if (obs0 !== e) begin
        errors++; $display("FAIL single_l0 r=%0d obs=%b exp=%b", r, obs0, e);
      end
      @(posedge clk);
      #1;
    end
    tick0 = 1'b0;
  endtask

  task automatic test_overrun();
    logic [12:0] e;
    do_reset();
    for (int r = 0; r < 25; r++) begin
      tick1 = (r == 10) || (r == 14);
      clr1  = (r == 20);
      if (r == 10) sb1.push_back(cyc + 7);
      @(negedge clk);
      e = expv(r, 10, 1, (r >= 15) && (r <= 20));
      checks++;
      if (obs1 !== e) begin
        errors++; $display("FAIL overrun r=%0d obs=%b exp=%b", r, obs1, e);
      end
      @(posedge clk);
      #1;
    end
    tick1 = 1'b0; clr1 = 1'b0;
  endtask

  task automatic test_clr_collision();
    logic [12:0] e;
    do_reset();
    for (int r = 0; r < 21; r++) begin
      tick1 = (r == 10) || (r == 11) || (r == 13);
      clr1  = (r == 13);
      if (r == 10) sb1.push_back(cyc + 7);
      @(negedge clk);
      e = expv(r, 10, 1, r >= 12);
      checks++;
      if (obs1 !== e) begin
        errors++; $display("FAIL clr_collision r=%0d obs=%b exp=%b", r, obs1, e);
      end
      @(posedge clk);
      #1;
    end
    tick1 = 1'b0; clr1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    int          t;
    int          npulse;
    npulse = 0;
    do_reset();
    for (int r = 0; r < 96; r++) begin
      tick1 = (r >= 10) && (r <= 82) && (((r - 10) % 8) == 0);
      if (tick1) sb1.push_back(cyc + 7);
      @(negedge clk);
      if (r <= 10) t = -100;
      else begin
        t = 10 + ((r - 11) / 8) * 8;
        if (t > 82) t = 82;
      end
      e = expv(r, t, 1, 1'b0);
      if (y_valid1) npulse++;
      checks++;
      if (obs1 !== e) begin
        errors++; $display("FAIL back_to_back r=%0d obs=%b exp=%b", r, obs1, e);
      end
      @(posedge clk);
      #1;
    end
    tick1 = 1'b0;
    checks++;
    if (npulse !== 10) begin
      errors++; $display("FAIL b2b_pulse_count got %0d expected 10", npulse);
    end
  endtask

  task automatic test_reset_abort();
    logic [12:0] e;
    do_reset();
    for (int r = 0; r < 30; r++) begin
      tick1 = (r == 10) || (r == 20);
      reset = (r == 13);
      if (r == 20) sb1.push_back(cyc + 7);
      @(negedge clk);
      e = (r < 14) ? expv(r, 10, 1, 1'b0) : expv(r, 20, 1, 1'b0);
      checks++;
      if (obs1 !== e) begin
        errors++; $display("FAIL reset_abort r=%0d obs=%b exp=%b", r, obs1, e);
      end
      @(posedge clk);
      #1;
    end
    tick1 = 1'b0; reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_l1();
    test_single_l0();
    test_overrun();
    test_clr_collision();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(posedge clk);
    checks++;
    if (sb1.size() !== 0) begin
      errors++; $display("FAIL sb1_leftover got %0d expected 0", sb1.size());
    end
    checks++;
    if (sb0.size() !== 0) begin
      errors++; $display("FAIL sb0_leftover got %0d expected 0", sb0.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
